// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of the receive, ALU and transmit signals around the ALU command sequencer.
// The master side is the sequencer; the slave side is the surrounding system.
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
);
    localparam int OUT_WIDTH = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] RX_D;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] ALU_A;
    logic [DATA_WIDTH-1:0] ALU_B;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  ALU_EN;
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic [DATA_WIDTH-1:0] TX_D;
    logic                  TX_D_VLD;
    logic                  TX_READY;
    logic                  BUSY;
    logic                  CMD_ERR;

    modport master (
        input  RX_D, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D, TX_D_VLD, BUSY, CMD_ERR
    );

    modport slave (
        output RX_D, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D, TX_D_VLD, BUSY, CMD_ERR
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command sequencer: parses CC/DD byte frames, fires the ALU for one cycle,
// captures the result and returns it low byte first under valid/ready.
module alu_cmd_ctrl #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  FUN_WIDTH  = 4,
    parameter int                  OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CMD_OPER   = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_NOOPER = 8'hDD,
    parameter int                  WAIT_MAX   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    alu_cmd_ctrl_if.master bus
);
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND_LO, SEND_HI
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_err_nxt;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [FUN_WIDTH-1:0]  r_fun;
    logic [OUT_WIDTH-1:0]  r_result;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_cmd_err;

    assign w_timeout = (r_cnt == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_D == CMD_OPER)        w_next = GET_A;
                    else if (bus.RX_D == CMD_NOOPER) w_next = GET_FUN;
                    else                             w_err_nxt = 1'b1;
                end
            end
            GET_A:    if (bus.RX_D_VLD) w_next = GET_B;
            GET_B:    if (bus.RX_D_VLD) w_next = GET_FUN;
            GET_FUN:  if (bus.RX_D_VLD) w_next = EXEC;
            EXEC:     w_next = WAIT_RES;
            WAIT_RES: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (bus.ALU_OUT_VLD) begin
                    w_next = SEND_LO;
                end else if (w_timeout) begin
                    w_next    = IDLE;
                    w_err_nxt = 1'b1;
                end
            end
            SEND_LO:  if (bus.TX_READY) w_next = SEND_HI;
            SEND_HI:  if (bus.TX_READY) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a       <= '0;
            r_b       <= '0;
            r_fun     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_err_nxt;
            if (r_state == GET_A && bus.RX_D_VLD)   r_a   <= bus.RX_D;
            if (r_state == GET_B && bus.RX_D_VLD)   r_b   <= bus.RX_D;
            if (r_state == GET_FUN && bus.RX_D_VLD) r_fun <= bus.RX_D[FUN_WIDTH-1:0];
            if (r_state == EXEC) r_cnt <= '0;
            if (r_state == WAIT_RES) begin
                if (bus.ALU_OUT_VLD) r_result <= bus.ALU_OUT;
                else                 r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.ALU_EN   = (r_state == EXEC);
        bus.TX_D_VLD = (r_state == SEND_LO) || (r_state == SEND_HI);
        bus.BUSY     = (r_state != IDLE);
        bus.CMD_ERR  = r_cmd_err;
        bus.ALU_A    = r_a;
        bus.ALU_B    = r_b;
        bus.ALU_FUN  = r_fun;
        bus.TX_D     = '0;
        if (r_state == SEND_LO)      bus.TX_D = r_result[DATA_WIDTH-1:0];
        else if (r_state == SEND_HI) bus.TX_D = r_result[OUT_WIDTH-1 -: DATA_WIDTH];
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: a small ALU with adjustable latency sits on
// the slave side, and a frame-level model predicts operands and returned bytes.
module tb_alu_cmd_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_cmd_ctrl_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus();

    alu_cmd_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

    int errors = 0;
    int checks = 0;

    // frame-level model of the operand/function registers
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [3:0] m_fun = 4'h0;

    logic [7:0]  tx_q[$];
    int          en_cnt = 0, err_cnt = 0;
    logic [7:0]  en_a, en_b;
    logic [3:0]  en_fun;
    int          alu_lat = 1;
    bit          alu_dead = 1'b0;
    int          alu_wait = 0;
    logic [15:0] alu_hold;

    function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        case (f)
            4'd0: return {8'h00, a} + {8'h00, b};
            4'd1: return {8'h00, a} - {8'h00, b};
            4'd2: return a * b;
            4'd3: return {8'h00, a & b};
            4'd4: return {8'h00, a | b};
            4'd5: return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // ALU: result valid alu_lat cycles after the enable cycle; garbage otherwise
    always @(posedge CLK) begin
        bus.ALU_OUT_VLD <= 1'b0;
        bus.ALU_OUT     <= 16'($urandom);
        if (RST) begin
            alu_wait <= 0;
        end else if (bus.ALU_EN && !alu_dead) begin
            if (alu_lat <= 1) begin
                bus.ALU_OUT_VLD <= 1'b1;
                bus.ALU_OUT     <= ref_alu(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
            end else begin
                alu_hold <= ref_alu(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
                alu_wait <= alu_lat - 1;
            end
        end else if (alu_wait > 0) begin
            alu_wait <= alu_wait - 1;
            if (alu_wait == 1) begin
                bus.ALU_OUT_VLD <= 1'b1;
                bus.ALU_OUT     <= alu_hold;
            end
        end
    end

    always @(posedge CLK) begin
        if (!RST) begin
            if (bus.TX_D_VLD && bus.TX_READY) tx_q.push_back(bus.TX_D);
            if (bus.ALU_EN) begin
                en_cnt <= en_cnt + 1;
                en_a   <= bus.ALU_A;
                en_b   <= bus.ALU_B;
                en_fun <= bus.ALU_FUN;
            end
            if (bus.CMD_ERR) err_cnt <= err_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_D     = b;
        bus.RX_D_VLD = 1'b1;
        @(negedge CLK);
        bus.RX_D_VLD = 1'b0;
        bus.RX_D     = 8'($urandom);
    endtask

    // returns at the negedge of the cycle after the last byte was accepted
    task automatic send_frame(input bit oper, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] f, input int gap);
        if (oper) begin
            m_a = a;
            m_b = b;
        end
        m_fun = f[3:0];
        send_byte(oper ? 8'hCC : 8'hDD);
        if (oper) begin
            repeat (gap) @(negedge CLK);
            send_byte(a);
            send_byte(b);
        end
        repeat (gap) @(negedge CLK);
        send_byte(f);
    endtask

    task automatic wait_bytes(input int n, input int budget, input bit rand_ready);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge CLK);
            if (rand_ready) bus.TX_READY = 1'($urandom);
            k++;
        end
        bus.TX_READY = 1'b1;
        checks++;
        if (tx_q.size() < n) begin
            errors++;
            $display("FAIL tx_timeout: got %0d bytes, expected %0d", tx_q.size(), n);
        end
    endtask

    task automatic wait_tx_vld(input string name);
        int k = 0;
        while (bus.TX_D_VLD !== 1'b1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (bus.TX_D_VLD !== 1'b1) begin
            errors++;
            $display("FAIL %s_tx_vld_timeout: TX_D_VLD=%b expected 1", name, bus.TX_D_VLD);
        end
    endtask

    task automatic test_reset();
        bus.RX_D = 8'hCC; bus.RX_D_VLD = 1'b0; bus.TX_READY = 1'b1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== 20'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 00000", {bus.ALU_A, bus.ALU_B, bus.ALU_FUN});
        end
        checks++;
        if ({bus.ALU_EN, bus.TX_D_VLD, bus.BUSY, bus.CMD_ERR} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.ALU_EN, bus.TX_D_VLD, bus.BUSY, bus.CMD_ERR});
        end
        checks++;
        if (bus.TX_D !== 8'h00) begin
            errors++;
            $display("FAIL reset_txd: got %h expected 00", bus.TX_D);
        end
    endtask

    task automatic test_add();
        int en0 = en_cnt;
        tx_q.delete();
        send_frame(1'b1, 8'h12, 8'h34, 8'h00, 0);
        checks++;
        if (bus.ALU_EN !== 1'b1) begin
            errors++;
            $display("FAIL add_en_cycle: got %b expected 1", bus.ALU_EN);
        end
        @(negedge CLK);
        checks++;
        if ({bus.ALU_EN, bus.TX_D_VLD} !== 2'b00) begin
            errors++;
            $display("FAIL add_wait_cycle: got %b expected 00", {bus.ALU_EN, bus.TX_D_VLD});
        end
        @(negedge CLK);
        checks++;
        if ({bus.TX_D_VLD, bus.TX_D} !== {1'b1, 8'h46}) begin
            errors++;
            $display("FAIL add_first_tx: got %b/%h expected 1/46", bus.TX_D_VLD, bus.TX_D);
        end
        wait_bytes(2, 20, 1'b0);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL add_busy_after: got %b expected 0", bus.BUSY);
        end
        checks++;
        if ({en_cnt - en0, en_a, en_b, en_fun} !== {32'd1, 8'h12, 8'h34, 4'h0}) begin
            errors++;
            $display("FAIL add_operands: got en=%0d a=%h b=%h f=%h expected en=1 a=12 b=34 f=0",
                     en_cnt - en0, en_a, en_b, en_fun);
        end
        checks++;
        if ({tx_q[0], tx_q[1]} !== 16'h4600) begin
            errors++;
            $display("FAIL add_bytes: got %h %h expected 46 00", tx_q[0], tx_q[1]);
        end
    endtask

    task automatic test_mul_backpressure();
        bit stable = 1'b1;
        tx_q.delete();
        bus.TX_READY = 1'b0;
        send_frame(1'b1, 8'hFF, 8'hFF, 8'h02, 1);
        wait_tx_vld("mul");
        repeat (5) begin
            if (bus.TX_D_VLD !== 1'b1 || bus.TX_D !== 8'h01) stable = 1'b0;
            @(negedge CLK);
        end
        checks++;
        if (!stable || tx_q.size() != 0) begin
            errors++;
            $display("FAIL mul_hold: stable=%b sent=%0d expected stable=1 sent=0", stable, tx_q.size());
        end
        bus.TX_READY = 1'b1;
        wait_bytes(2, 20, 1'b0);
        checks++;
        if ({tx_q[0], tx_q[1]} !== 16'h01FE) begin
            errors++;
            $display("FAIL mul_bytes: got %h %h expected 01 FE", tx_q[0], tx_q[1]);
        end
    endtask

    task automatic test_reuse();
        tx_q.delete();
        send_frame(1'b0, 8'h00, 8'h00, 8'h01, 0);
        wait_bytes(2, 20, 1'b0);
        checks++;
        if ({en_a, en_b, en_fun} !== {8'hFF, 8'hFF, 4'h1}) begin
            errors++;
            $display("FAIL reuse_operands: got a=%h b=%h f=%h expected a=FF b=FF f=1", en_a, en_b, en_fun);
        end
        checks++;
        if ({tx_q[0], tx_q[1]} !== 16'h0000) begin
            errors++;
            $display("FAIL reuse_bytes: got %h %h expected 00 00", tx_q[0], tx_q[1]);
        end
    endtask

    task automatic test_bad_opcode();
        int e0 = err_cnt;
        bit busy_seen = 1'b0;
        send_byte(8'h55);
        repeat (5) begin
            if (bus.BUSY !== 1'b0) busy_seen = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (err_cnt - e0 != 1 || busy_seen) begin
            errors++;
            $display("FAIL bad_opcode: got err_cycles=%0d busy=%b expected 1/0", err_cnt - e0, busy_seen);
        end
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        int first = 0;
        bit tx_seen = 1'b0;
        tx_q.delete();
        alu_dead = 1'b1;
        send_frame(1'b0, 8'h00, 8'h00, 8'h03, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (bus.CMD_ERR === 1'b1 && first == 0) first = k;
            if (bus.TX_D_VLD !== 1'b0) tx_seen = 1'b1;
        end
        alu_dead = 1'b0;
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL timeout_latency: got err at +%0d expected +5", first);
        end
        checks++;
        if (err_cnt - e0 != 1 || tx_seen || tx_q.size() != 0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got err=%0d tx=%b busy=%b expected 1/0/0",
                     err_cnt - e0, tx_seen, bus.BUSY);
        end
    endtask

    task automatic test_ignored();
        int e0 = err_cnt;
        int n0 = en_cnt;
        tx_q.delete();
        alu_lat = 3;
        bus.TX_READY = 1'b0;
        send_frame(1'b1, 8'h0A, 8'h05, 8'h01, 0);
        // bytes landing in EXEC and WAIT_RES
        bus.RX_D = 8'hCC; bus.RX_D_VLD = 1'b1;
        @(negedge CLK); bus.RX_D = 8'h55;
        @(negedge CLK); bus.RX_D = 8'hDD;
        @(negedge CLK); bus.RX_D_VLD = 1'b0;
        wait_tx_vld("ign");
        bus.RX_D = 8'h55; bus.RX_D_VLD = 1'b1;
        @(negedge CLK); bus.RX_D = 8'hCC;
        @(negedge CLK); bus.RX_D_VLD = 1'b0;
        bus.TX_READY = 1'b1;
        wait_bytes(2, 20, 1'b0);
        repeat (4) @(negedge CLK);
        alu_lat = 1;
        checks++;
        if ({tx_q[0], tx_q[1]} !== 16'h0500 || tx_q.size() != 2) begin
            errors++;
            $display("FAIL ignored_bytes: got %h %h (n=%0d) expected 05 00 (n=2)", tx_q[0], tx_q[1], tx_q.size());
        end
        checks++;
        if (err_cnt != e0 || en_cnt - n0 != 1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ignored_side: got err=%0d en=%0d busy=%b expected 0/1/0",
                     err_cnt - e0, en_cnt - n0, bus.BUSY);
        end
    endtask

    task automatic test_reset_mid();
        tx_q.delete();
        bus.TX_READY = 1'b0;
        send_frame(1'b1, 8'($urandom), 8'($urandom), 8'h02, 0);
        wait_tx_vld("rstmid");
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({bus.TX_D_VLD, bus.BUSY, bus.TX_D, bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== 30'h0) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b busy=%b txd=%h a=%h b=%h f=%h expected all 0",
                     bus.TX_D_VLD, bus.BUSY, bus.TX_D, bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
        end
        RST = 1'b0;
        m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0;
        bus.TX_READY = 1'b1;
        tx_q.delete();
        send_frame(1'b1, 8'h03, 8'h02, 8'h00, 0);
        wait_bytes(2, 20, 1'b0);
        checks++;
        if ({tx_q[0], tx_q[1]} !== 16'h0500 || tx_q.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_after: got %h %h (n=%0d) expected 05 00", tx_q[0], tx_q[1], tx_q.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [15:0] exp_res;
            logic [7:0]  junk;
            int e0 = err_cnt;
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                while (junk == 8'hCC || junk == 8'hDD) junk = 8'($urandom);
                send_byte(junk);
                @(negedge CLK);
                checks++;
                if (err_cnt - e0 != 1) begin
                    errors++;
                    $display("FAIL rand_junk[%0d]: got err=%0d for %h expected 1", i, err_cnt - e0, junk);
                end
            end
            tx_q.delete();
            send_frame(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
                       $urandom_range(0, 2));
            exp_res = ref_alu(m_a, m_b, m_fun);
            wait_bytes(2, 200, 1'b1);
            checks++;
            if ({en_a, en_b, en_fun} !== {m_a, m_b, m_fun}) begin
                errors++;
                $display("FAIL rand_operands[%0d]: got %h %h %h expected %h %h %h",
                         i, en_a, en_b, en_fun, m_a, m_b, m_fun);
            end
            checks++;
            if ({tx_q[1], tx_q[0]} !== exp_res) begin
                errors++;
                $display("FAIL rand_result[%0d]: got %h%h expected %h", i, tx_q[1], tx_q[0], exp_res);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        bus.RX_D = 8'h00; bus.RX_D_VLD = 1'b0; bus.TX_READY = 1'b1;
        test_reset();
        test_add();
        test_mul_backpressure();
        test_reuse();
        test_bad_opcode();
        test_timeout();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer that owns the system ALU. It parses a byte-stream command frame from the receive path, loads operand and function registers, and pulses the ALU enable for one cycle. It captures the registered 16-bit ALU result when valid, then returns it on the transmit path as two bytes, low byte first, under a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, operand and byte width.
FUN_WIDTH, 4, ALU function-code width; taken from the LSBs of the function byte.
OUT_WIDTH, 2*DATA_WIDTH, ALU result width.
CMD_OPER, 8'hCC, opcode for a frame that carries new operands: CC, A, B, FUN.
CMD_NOOPER, 8'hDD, opcode for a frame that reuses stored operands: DD, FUN.
WAIT_MAX, 4, number of cycles spent in WAIT_RES before the result wait times out.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
RX_D  in  DATA_WIDTH  received command/data byte.
RX_D_VLD  in  1  RX_D valid, one-cycle strobe per byte.
ALU_A  out  DATA_WIDTH  operand A register.
ALU_B  out  DATA_WIDTH  operand B register.
ALU_FUN  out  FUN_WIDTH  function register.
ALU_EN  out  1  ALU enable.
ALU_OUT  in  OUT_WIDTH  registered ALU result.
ALU_OUT_VLD  in  1  ALU result valid.
TX_D  out  DATA_WIDTH  result byte to transmit.
TX_D_VLD  out  1  TX_D valid.
TX_READY  in  1  transmit sink accepts the byte when high together with TX_D_VLD.
BUSY  out  1  high in every state except IDLE.
CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - ALU_A, ALU_B, ALU_FUN, the result register and the timeout counter clear to 0.
  - ALU_EN, TX_D_VLD, BUSY and CMD_ERR are 0; TX_D is 0.
  - Reset mid-frame or mid-transmit abandons the operation with no partial output.
- States: IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT_RES, SEND_LO, SEND_HI.
- IDLE, on RX_D_VLD:
  - RX_D==CMD_OPER: go to GET_A.
  - RX_D==CMD_NOOPER: go to GET_FUN.
  - Any other value: CMD_ERR=1 for the next cycle only; stay in IDLE.
- GET_A: on RX_D_VLD, ALU_A<=RX_D, go to GET_B.
- GET_B: on RX_D_VLD, ALU_B<=RX_D, go to GET_FUN.
- GET_FUN: on RX_D_VLD, ALU_FUN<=RX_D[FUN_WIDTH-1:0], go to EXEC.
- With no RX_D_VLD, the GET_* states wait indefinitely; there is no inter-byte timeout.
- EXEC: ALU_EN=1 for exactly this one cycle; go to WAIT_RES and clear the timeout counter.
- WAIT_RES:
  - ALU_OUT_VLD=1: result<=ALU_OUT, go to SEND_LO.
  - Otherwise increment the counter.
  - After WAIT_MAX cycles in WAIT_RES without ALU_OUT_VLD: pulse CMD_ERR for one cycle, go to IDLE, transmit nothing.
- SEND_LO: TX_D=result[7:0], TX_D_VLD=1. When TX_READY=1 in the same cycle, go to SEND_HI.
- SEND_HI: TX_D=result[15:8], TX_D_VLD=1. When TX_READY=1, go to IDLE.
- While TX_D_VLD=1 and TX_READY=0, TX_D is held stable.
- ALU_EN and TX_D_VLD are Moore outputs decoded from state. TX_D is muxed from the result register.
- ALU_A, ALU_B and ALU_FUN keep their values after a command completes; a CMD_NOOPER frame relies on this.
- RX_D_VLD in EXEC, WAIT_RES, SEND_LO or SEND_HI: the byte is dropped silently, with no CMD_ERR and no state effect.
- Latency, with a 1-cycle ALU: final command byte accepted at edge n; EXEC in cycle n+1; ALU_OUT_VLD high in cycle n+2; TX_D_VLD first high in cycle n+3.
- An RX byte accepted on the same edge that SEND_HI completes is not seen: IDLE begins on the following cycle.

Test Plan:
- Addition: RX CC,12,34,00 -> ALU_EN pulses exactly one cycle with A=12, B=34, FUN=0; TX bytes 46 then 00; BUSY falls after the 00 byte is accepted.
- Multiplication with backpressure: RX CC,FF,FF,02, TX_READY held low 5 cycles -> TX_D=01 stays stable with TX_D_VLD=1 throughout, then 01, FE.
- Operand reuse: after the multiplication frame, RX DD,01 -> A and B still FF, FUN=1; TX 00, 00.
- Error paths:
  - RX 55 in IDLE -> CMD_ERR high exactly one cycle, BUSY stays 0.
  - ALU_OUT_VLD tied low -> CMD_ERR pulses after WAIT_MAX=4 WAIT_RES cycles, no TX_D_VLD, state returns to IDLE.
- Ignored input: RX bytes injected during WAIT_RES and SEND_LO -> no change to the result or the byte sequence.
- Reset mid-operation: assert RST during SEND_LO -> on the next edge TX_D_VLD=0, all registers 0; a following CC,03,02,00 frame yields TX 05, 00.
